memory_responder: RTL and testbench
===================================

# memory_responder

Multi-cycle word memory that answers the CPU's `readM`/`writeM`/`address`/`data` bus from the memory side. It accepts one access at a time and holds it for a programmable latency. It then completes the access with a one-cycle `ack`: it commits the write, or drives read data onto the shared tri-state `data` bus. It sits opposite the multi-cycle `cpu` in the top-level testbench/SoC and replaces a purely combinational memory.

## Interface
Parameters:
- `WORD_SIZE`, 16, data and address width.
- `DEPTH`, 256, number of words. Power of two. `AW = $clog2(DEPTH)`.
- `LATENCY`, 2, cycles from accept edge to `ack`. Must be ≥1.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `Reset_N`  in  1  reset, asynchronous, active-low. Reset Reset_N, asynchronous, active-low; clock clk.
- `readM`  in  1  read request, level, held until `ack`.
- `writeM`  in  1  write request, level, held until `ack`.
- `address`  in  WORD_SIZE  word address.
- `data`  inout  WORD_SIZE  write data from the CPU; read data from this block.
- `ack`  out  1  access complete, one-cycle pulse.
- `busy`  out  1  access in progress.
- `err`  out  1  out-of-range access flag, valid with `ack`.

## Operation
- State machine with three states:
  - IDLE → BUSY:
    - Taken on an edge where exactly one of `readM`/`writeM` is high.
    - Latches `op`, `address` and `data` (write only).
    - Sets `cnt = LATENCY-1`.
  - BUSY, `cnt != 0`: `cnt` decrements each edge.
  - BUSY, `cnt == 0` → DONE:
    - Write: `mem[addr_q[AW-1:0]] <= wdata_q`.
    - Read: `rdata_q <= mem[addr_q[AW-1:0]]`.
  - DONE → IDLE unconditionally on the next edge.
- `readM` and `writeM` high together in IDLE: no request, block stays IDLE, no `ack`.
- Request inputs are ignored in BUSY and DONE. The latched values are authoritative.
- Bus drive:
  - `data = (state==DONE && op==RD) ? rdata_q : 'z`.
  - `data` is never driven in IDLE or BUSY, or during writes.
- Register outputs:
  - `ack` = 1 only in DONE.
  - `busy` = 1 in BUSY and DONE.
- Array contents are not cleared by reset and are undefined at power-up. The bench preloads them via hierarchical access.
- Reset mid-access:
  - Returns to IDLE with `cnt = 0`.
  - An uncommitted write is dropped.
  - `data` is released immediately.
- Reset values: state IDLE, `ack` 0, `busy` 0, `err` 0, `cnt` 0, `data` Z, `rdata_q` 0.

## Timing
- Accept at edge n. DONE is entered at edge n+LATENCY. `ack`, read data and `err` are valid from edge n+LATENCY until edge n+LATENCY+1.
- Write commits at edge n+LATENCY. A read issued afterwards sees the new value.
- The requester samples `ack` at edge n+LATENCY+1 and drops `readM`/`writeM` there. The block is IDLE at that same edge.
- The earliest next accept is edge n+LATENCY+2. Back-to-back accesses therefore have a period of LATENCY+2 cycles.
- If the requester still holds a request at edge n+LATENCY+2, it is accepted as a new access. Requesters must deassert on `ack`.
- `LATENCY=1`: BUSY lasts exactly one cycle.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - An access with `address >= DEPTH` runs the normal FSM and latency.
  - The write is dropped.
  - A read returns all-ones.
  - `err` = 1 in the DONE cycle.
- `MEM_RANGE_CHECK_EN` undefined:
  - `err` is tied to 0.
  - Upper address bits are ignored, so addresses alias modulo DEPTH.

## Test plan
- Reset then idle: hold `Reset_N`=0 for 3 cycles, then release with no requests for 10 cycles → `ack`/`busy`/`err` stay 0, `data` stays Z throughout.
- Read latency: preload `mem[0x10]`=`0xBEEF`, LATENCY=2; assert `readM` with `address`=`0x0010` at edge 0 → `busy` high from edge 0, `ack`=1 and `data`=`0xBEEF` in the cycle after edge 2 only, `data` Z after edge 3.
- Write then read: write `0x1234` to `0x0020` → `ack` after 2 cycles; read `0x0020` → `data`=`0x1234`; a write accept-to-accept gap of 4 cycles is measured.
- Held request and conflict: hold `readM` one cycle past `ack` → a second `ack` occurs 4 cycles after the first. Assert `readM`=`writeM`=1 for 5 cycles → no `ack`, `busy`=0.
- Reset mid-write: accept a write of `0x5555` to `0x30` (old value `0xAAAA`), pulse `Reset_N` low in BUSY → no `ack`, a subsequent read returns `0xAAAA`.
- Range, DEPTH=256:
  - With the macro: write `0x7777` to `0x0105`, then read `0x0105` → `err`=1 with each `ack`, read data `0xFFFF`, `mem[0x05]` unchanged.
  - Without the macro: the same write lands in `mem[0x05]` and `err` stays 0.

Source files
------------

// File: rtl/memory_responder.sv
// Multi-cycle word memory: accepts one readM/writeM access, completes it LATENCY cycles later with a one-cycle ack.
// No backpressure beyond busy; requests are ignored until IDLE. Optional range check via MEM_RANGE_CHECK_EN.
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 Reset_N,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 ack,
    output logic                 busy,
    output logic                 err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic                  oor;
    logic [WORD_SIZE-1:0]  mem [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
    // Extra bit keeps the compare correct even when DEPTH == 2**WORD_SIZE.
    assign oor = ({1'b0, addr_q} >= (WORD_SIZE+1)'(DEPTH));
`else
    logic unused_addr_hi;
    assign oor            = 1'b0;
    assign unused_addr_hi = ^addr_q[WORD_SIZE-1:AW];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (readM ^ writeM) begin
                    state_d = BUSY;
                    op_wr_d = writeM;
                    addr_d  = address;
                    cnt_d   = CW'(LATENCY - 1);
                    if (writeM) wdata_d = data;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = DONE;
                    err_d   = oor;
                    if (op_wr_q) mem_we  = !oor;
                    else         rdata_d = oor ? '1 : mem[addr_q[AW-1:0]];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; mem_we derives from the reset state so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q[AW-1:0]] <= wdata_q;
    end

    assign ack  = (state_q == DONE);
    assign busy = (state_q != IDLE);
    assign err  = err_q;
    assign data = (state_q == DONE && !op_wr_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed accesses push expected acks into a scoreboard; a monitor pops on ack.
module tb_memory_responder;

    localparam int L = 2;

    typedef struct {
        logic        rd;
        logic [15:0] rdat;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset_N;
    logic        readM, writeM;
    logic [15:0] address, tb_wdat;
    logic        tb_drv;
    wire  [15:0] data;
    logic        ack, busy, err;

    exp_t sb[$];
    exp_t me;
    int   cyc = 0;
    int   vec = 0;
    int   bad = 0;

    // Released bus floats high, so "not driven" reads as all-ones.
    pullup (data);
    assign data = tb_drv ? tb_wdat : 'z;

    memory_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(L)) dut (
        .clk     (clk),
        .Reset_N (Reset_N),
        .readM   (readM),
        .writeM  (writeM),
        .address (address),
        .data    (data),
        .ack     (ack),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_ack(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = ack;
        end
        if (!seen) begin
            vec++;
            bad++;
            $display("FAIL %s: no ack within 20 cycles (cyc %0d)", nm, cyc);
        end
    endtask

    // Called at a negedge; returns at a negedge one cycle after ack.
    task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] rd_exp, input bit err_exp, output int acc);
        exp_t e;
        readM   = !wr;
        writeM  = wr;
        address = a;
        tb_wdat = wd;
        tb_drv  = wr;
        e.rd = !wr; e.rdat = rd_exp; e.err = err_exp; e.cyc = cyc + 1 + L;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("accept_busy", busy, 1);
        acc = cyc;
        wait_ack("access_ack");
        readM  = 1'b0;
        writeM = 1'b0;
        tb_drv = 1'b0;
        @(negedge clk);
        chk("ack_pulse", ack, 0);
        chk("idle_after", busy, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (ack) begin
            if (sb.size() == 0) begin
                vec++;
                bad++;
                $display("FAIL unexpected_ack: got ack expected none (cyc %0d)", cyc);
            end else begin
                me = sb.pop_front();
                chk("ack_cycle", cyc, me.cyc);
                chk("ack_err", err, me.err);
                if (me.rd) chk("rd_data", data, me.rdat);
            end
        end else begin
            chk("err_no_ack", err, 0);
            if (!tb_drv) chk("data_released", data, 16'hFFFF);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1, a2, tmp;
        exp_t e;
        Reset_N = 1'b1; readM = 1'b0; writeM = 1'b0;
        address = '0; tb_wdat = '0; tb_drv = 1'b0;
        #1 Reset_N = 1'b0;
        dut.mem[8'h05] = 16'h0BAD;
        dut.mem[8'h10] = 16'hBEEF;
        dut.mem[8'h30] = 16'hAAAA;

        repeat (3) @(negedge clk);
        Reset_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ack", ack, 0);
            chk("idle_busy", busy, 0);
            chk("idle_err", err, 0);
        end

        access(1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, tmp);

        access(1'b1, 16'h0020, 16'h1234, 16'h0, 1'b0, a1);
        access(1'b1, 16'h0021, 16'h4321, 16'h0, 1'b0, a2);
        chk("write_gap", a2 - a1, L + 2);
        access(1'b0, 16'h0020, 16'h0, 16'h1234, 1'b0, tmp);
        access(1'b0, 16'h0021, 16'h0, 16'h4321, 1'b0, tmp);

        // Request held through the edge after IDLE is re-entered: second access follows.
        readM = 1'b1; address = 16'h0010;
        e.rd = 1'b1; e.rdat = 16'hBEEF; e.err = 1'b0; e.cyc = cyc + 1 + L;
        sb.push_back(e);
        e.cyc = e.cyc + L + 2;
        sb.push_back(e);
        wait_ack("held_ack1");
        @(negedge clk);
        @(negedge clk);
        readM = 1'b0;
        wait_ack("held_ack2");
        @(negedge clk);
        chk("held_idle", busy, 0);

        readM = 1'b1; writeM = 1'b1; address = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("conflict_ack", ack, 0);
            chk("conflict_busy", busy, 0);
        end
        readM = 1'b0; writeM = 1'b0;
        @(negedge clk);

        writeM = 1'b1; address = 16'h0030; tb_wdat = 16'h5555; tb_drv = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_accept", busy, 1);
        @(negedge clk);
        Reset_N = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        writeM = 1'b0; tb_drv = 1'b0;
        @(negedge clk);
        Reset_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_ack", ack, 0);
        end
        access(1'b0, 16'h0030, 16'h0, 16'hAAAA, 1'b0, tmp);

`ifdef MEM_RANGE_CHECK_EN
        access(1'b1, 16'h0105, 16'h7777, 16'h0, 1'b1, tmp);
        access(1'b0, 16'h0105, 16'h0, 16'hFFFF, 1'b1, tmp);
        chk("mem05_kept", dut.mem[8'h05], 16'h0BAD);
`else
        access(1'b1, 16'h0105, 16'h7777, 16'h0, 1'b0, tmp);
        access(1'b0, 16'h0005, 16'h0, 16'h7777, 1'b0, tmp);
        chk("mem05_alias", dut.mem[8'h05], 16'h7777);
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
